// File: rtl/cordic_pkg.sv
// Shared constants for the bit-serial CORDIC sequencer and its datapath:
// controller states, default word/iteration sizes and mode encodings.
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;
  localparam int CORDIC_ITERS = 16;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DECIDE,
    SHIFT,
    DONE
  } cordic_state_e;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// Nested bit/iteration counter for the serial CORDIC; bit index advances on en_i,
// iteration index advances when the bit index wraps. Single-cycle clear, no stall beyond en_i.
module cordic_iter_counter
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITERS = CORDIC_ITERS,
  localparam int BW = idx_width(WIDTH),
  localparam int IW = idx_width(ITERS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [BW-1:0] bit_idx_o,
  output logic [IW-1:0] iter_idx_o,
  output logic          last_bit_o,
  output logic          last_iter_o,
  output logic          tap_sext_o
);

  logic [BW-1:0] bit_q, bit_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [BW:0]   tap_sum;

  assign last_bit_o  = (bit_q == BW'(WIDTH - 1));
  assign last_iter_o = (iter_q == IW'(ITERS - 1));

  // One extra bit so bit+iter never wraps before the compare.
  assign tap_sum    = {1'b0, bit_q} + (BW + 1)'(iter_q);
  assign tap_sext_o = (tap_sum >= (BW + 1)'(WIDTH));

  always_comb begin
    bit_d  = bit_q;
    iter_d = iter_q;
    if (clr_i) begin
      bit_d  = '0;
      iter_d = '0;
    end else if (en_i) begin
      if (last_bit_o) begin
        bit_d  = '0;
        iter_d = last_iter_o ? '0 : iter_q + IW'(1);
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q  <= '0;
      iter_q <= '0;
    end else begin
      bit_q  <= bit_d;
      iter_q <= iter_d;
    end
  end

  assign bit_idx_o  = bit_q;
  assign iter_idx_o = iter_q;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the bit-serial CORDIC: LOAD, then ITERS x (DECIDE + WIDTH SHIFT cycles), then a
// one-cycle DONE pulse; total 2+ITERS*(WIDTH+1) cycles after accept. start is ignored while busy.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITERS = CORDIC_ITERS,
  localparam int BW = idx_width(WIDTH),
  localparam int IW = idx_width(ITERS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          z_sign,
  input  logic          y_sign,
  output logic          busy,
  output logic          done,
  output logic          load,
  output logic          shift_en,
  output logic          sign_latch,
  output logic          dir,
  output logic [BW-1:0] bit_idx,
  output logic [IW-1:0] iter_idx,
  output logic          lsb,
  output logic          tap_sext
);

  cordic_state_e state_q;
  logic          mode_q;
  logic          busy_q, done_q, load_q, shift_en_q, sign_latch_q, dir_q;
  logic          accept;
  logic          last_bit, last_iter, tap_raw;

  assign accept = (state_q == IDLE) && start;

  cordic_iter_counter #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (shift_en_q),
    .clr_i       (accept),
    .bit_idx_o   (bit_idx),
    .iter_idx_o  (iter_idx),
    .last_bit_o  (last_bit),
    .last_iter_o (last_iter),
    .tap_sext_o  (tap_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_ROTATE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_q       <= 1'b0;
      shift_en_q   <= 1'b0;
      sign_latch_q <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            mode_q  <= mode;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q      <= DECIDE;
          load_q       <= 1'b0;
          sign_latch_q <= 1'b1;
        end
        DECIDE: begin
          // Direction is frozen here and held for every bit of the iteration.
          state_q      <= SHIFT;
          sign_latch_q <= 1'b0;
          shift_en_q   <= 1'b1;
          dir_q        <= (mode_q == MODE_VECTOR) ? y_sign : ~z_sign;
        end
        SHIFT: begin
          if (last_bit) begin
            shift_en_q <= 1'b0;
            if (last_iter) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= DECIDE;
              sign_latch_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          load_q       <= 1'b0;
          shift_en_q   <= 1'b0;
          sign_latch_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign load       = load_q;
  assign shift_en   = shift_en_q;
  assign sign_latch = sign_latch_q;
  assign dir        = dir_q;
  // Per-bit strobes only mean something while shifting; quiet otherwise.
  assign lsb        = shift_en_q && (bit_idx == '0);
  assign tap_sext   = shift_en_q && tap_raw;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl (16/16): stimulus pushes the expected per-cycle
// trace of each run, a negedge monitor pops and compares whenever the sequencer is busy.
module tb_cordic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start, mode, z_sign, y_sign;
  logic       busy, done, load, shift_en, sign_latch, dir, lsb, tap_sext;
  logic [3:0] bit_idx, iter_idx;

  always #5 clk = ~clk;

  cordic_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .z_sign     (z_sign),
    .y_sign     (y_sign),
    .busy       (busy),
    .done       (done),
    .load       (load),
    .shift_en   (shift_en),
    .sign_latch (sign_latch),
    .dir        (dir),
    .bit_idx    (bit_idx),
    .iter_idx   (iter_idx),
    .lsb        (lsb),
    .tap_sext   (tap_sext)
  );

  typedef struct packed {
    int         cyc;
    logic       done, load, sh, sl, dir, lsb, tap, chk_idx;
    logic [3:0] bit_e, it_e;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          run_shift = 0;
  int          run_p = 0;
  logic        run_active = 1'b0;
  logic        toggle_en = 1'b0;
  logic        mode_req = 1'b0;
  logic        model_dir = 1'b0;
  logic [15:0] zpat = '0;
  logic [15:0] ypat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected-trace model
  task automatic push(input int c, input logic ld, input logic sl, input logic sh,
                      input logic dn, input logic dr, input int b, input int it,
                      input logic chk);
    rec_t r;
    r.cyc     = c;
    r.load    = ld;
    r.sl      = sl;
    r.sh      = sh;
    r.done    = dn;
    r.dir     = dr;
    r.lsb     = sh && (b == 0);
    r.tap     = sh && ((b + it) >= 16);
    r.chk_idx = chk;
    r.bit_e   = 4'(b);
    r.it_e    = 4'(it);
    q.push_back(r);
  endtask

  task automatic push_run(input int p, input logic m);
    logic d;
    d = model_dir;
    push(p + 1, 1'b1, 1'b0, 1'b0, 1'b0, d, 0, 0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      push(p + 2 + i * 17, 1'b0, 1'b1, 1'b0, 1'b0, d, 0, i, 1'b1);
      d = m ? ypat[i] : ~zpat[i];
      for (int b = 0; b < 16; b++)
        push(p + 3 + i * 17 + b, 1'b0, 1'b0, 1'b1, 1'b0, d, b, i, 1'b1);
    end
    push(p + 274, 1'b0, 1'b0, 1'b0, 1'b1, d, 0, 0, 1'b0);
    model_dir = d;
  endtask

  task automatic begin_run(input logic m, input logic tog, input logic [15:0] zp,
                           input logic [15:0] yp);
    mode_req  = m;
    toggle_en = 1'b0;
    zpat      = zp;
    ypat      = yp;
    @(negedge clk);
    run_p      = cyc;
    start      = 1'b1;
    push_run(cyc, m);
    run_active = 1'b1;
    toggle_en  = tog;
  endtask

  task automatic end_run();
    run_active = 1'b0;
    toggle_en  = 1'b0;
  endtask

  // Input driver: true sign only in DECIDE cycles, noise elsewhere; optional mode toggling.
  always @(posedge clk) begin
    int k;
    int it;
    #1;
    k  = cyc - run_p;
    it = (k - 2) / 17;
    if (run_active && toggle_en && k >= 1) mode = ~mode;
    else if (!run_active) mode = mode_req;
    if (run_active && k >= 2 && ((k - 2) % 17) == 0 && it < 16) begin
      z_sign = zpat[it[3:0]];
      y_sign = ypat[it[3:0]];
    end else begin
      z_sign = 1'($urandom_range(0, 1));
      y_sign = 1'($urandom_range(0, 1));
    end
  end

  // Monitor
  always @(negedge clk) begin
    rec_t        r;
    logic [15:0] act, expv, msk;
    act = {busy, done, load, shift_en, sign_latch, dir, lsb, tap_sext, bit_idx, iter_idx};
    if (!rst_n) begin
      q.delete();
      run_shift = 0;
      total++;
      if (act != 16'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0000", cyc, act);
      end
    end else if (busy) begin
      if (shift_en) run_shift++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_busy cyc=%0d got busy=1 want busy=0", cyc);
      end else begin
        r    = q.pop_front();
        expv = {1'b1, r.done, r.load, r.sh, r.sl, r.dir, r.lsb, r.tap, r.bit_e, r.it_e};
        msk  = r.chk_idx ? 16'hFFFF : 16'hFF00;
        if (r.cyc != cyc || (act & msk) != (expv & msk)) begin
          bad++;
          $display("FAIL trace cyc=%0d want_cyc=%0d got=%h want=%h mask=%h",
                   cyc, r.cyc, act, expv, msk);
        end
        if (r.done) begin
          total++;
          if (run_shift != 256) begin
            bad++;
            $display("FAIL shift_count cyc=%0d got=%0d want=256", cyc, run_shift);
          end
          run_shift = 0;
        end
      end
    end else begin
      total++;
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        bad++;
        $display("FAIL missing_output cyc=%0d want_cyc=%0d got busy=0 want busy=1",
                 cyc, q[0].cyc);
        void'(q.pop_front());
      end else if ({busy, done, load, shift_en, sign_latch, lsb, tap_sext} != 7'h0) begin
        bad++;
        $display("FAIL idle_outputs cyc=%0d got=%b want=0000000", cyc,
                 {busy, done, load, shift_en, sign_latch, lsb, tap_sext});
      end
    end
  end

  initial begin
    start = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Rotation; z_sign 0 then 1; start pulses mid-run and in DONE must be ignored.
    begin_run(1'b0, 1'b0, 16'h6C32, 16'h0000);
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (223) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    end_run();

    // Vectoring with mode toggling every cycle after accept.
    begin_run(1'b1, 1'b1, 16'h1234, 16'h35A9);
    @(negedge clk) start = 1'b0;
    repeat (276) @(negedge clk);
    end_run();

    // start held high: one run, then re-accept in the first idle cycle.
    begin_run(1'b0, 1'b0, 16'h0F0F, 16'h0000);
    repeat (275) @(negedge clk);
    run_p = cyc;
    push_run(cyc, 1'b0);
    @(negedge clk) start = 1'b0;
    repeat (276) @(negedge clk);
    end_run();

    // Asynchronous reset 100 cycles into a run.
    begin_run(1'b1, 1'b0, 16'h0000, 16'hFFFF);
    @(negedge clk) start = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst_n = 1'b0;
    model_dir = 1'b0;
    end_run();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-latency run after reset.
    begin_run(1'b0, 1'b0, 16'h8001, 16'h0000);
    @(negedge clk) start = 1'b0;
    repeat (276) @(negedge clk);
    end_run();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
